// File: rtl/mem_nzlat_initiator.sv
// Core valid/ready to nonzero-latency pulse memory adapter.
// One access in flight, bounded by a completion timeout.
module mem_nzlat_initiator #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 1024,
  parameter int TIMEOUT = 64,
  localparam int ADDR_WIDTH = $clog2(DEPTH),
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [STRB_WIDTH-1:0] req_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_write,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [STRB_WIDTH-1:0] mem_wstrb,
  output logic                  mem_write,
  output logic                  mem_read,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT, RESP, DRAIN
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          late;
  logic          wr;
  logic          expire;

  assign req_ready = (state == IDLE);
  assign expire = (TIMEOUT != 0) && (cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      late      <= 1'b0;
      wr        <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_write <= 1'b0;
      rsp_err   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      mem_write <= 1'b0;
      mem_read  <= 1'b0;
    end else begin
      mem_write <= 1'b0;
      mem_read  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            wr        <= req_write;
            mem_addr  <= req_addr;
            mem_wdata <= req_wdata;
            mem_wstrb <= req_wstrb;
            mem_write <= req_write;
            mem_read  <= !req_write;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (mem_ready) begin
            rsp_rdata <= wr ? '0 : mem_rdata;
            rsp_write <= wr;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (expire) begin
            rsp_rdata <= '0;
            rsp_write <= wr;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            late      <= 1'b0;
            state     <= RESP;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (mem_ready) late <= 1'b1;
          // a completion landing with the handshake still counts as late
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state <= (rsp_err && !(late || mem_ready)) ? DRAIN : IDLE;
          end
        end
        DRAIN: begin
          if (mem_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_nzlat_initiator.sv
// Bench for mem_nzlat_initiator: pulse-protocol memory responder
// plus a queue of expected responses checked at each completion.
module tb_mem_nzlat_initiator;

  localparam int DW = 32;
  localparam int DEPTH = 1024;
  localparam int AW = $clog2(DEPTH);
  localparam int SW = DW / 8;
  localparam int TO = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [SW-1:0] req_wstrb;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_write;
  logic          rsp_err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [SW-1:0] mem_wstrb;
  logic          mem_write;
  logic          mem_read;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          write;
    logic          err;
  } rsp_t;
  rsp_t sb[$];

  mem_nzlat_initiator #(
    .DATA_WIDTH(DW),
    .DEPTH(DEPTH),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_write(rsp_write),
    .rsp_err(rsp_err),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_write(mem_write),
    .mem_read(mem_read),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // memory responder: ready L+1 edges after the command pulse
  int lat = 0;
  bit mute = 1'b0;
  bit kick = 1'b0;
  bit kick_seen;
  int cnt;
  bit rd;
  logic [AW-1:0] ra;
  bit [DW-1:0] store [DEPTH];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      cnt = -1;
      kick_seen = kick;
    end else begin
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      if (mem_write) begin
        for (int b = 0; b < SW; b++)
          if (mem_wstrb[b])
            store[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
      end
      if (mem_write || mem_read) begin
        cnt = mute ? -1 : lat;
        rd = mem_read;
        ra = mem_addr;
      end else if (cnt > 0) begin
        cnt--;
      end
      if (cnt == 0) begin
        mem_ready <= 1'b1;
        mem_rdata <= rd ? store[ra] : 32'hDEAD_BEEF;
        cnt = -1;
      end
      if (kick != kick_seen) begin
        kick_seen = kick;
        mem_ready <= 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic access(
    input bit          w,
    input logic [AW-1:0] a,
    input logic [DW-1:0] d,
    input logic [SW-1:0] s,
    input logic [DW-1:0] exp_rd,
    input bit          exp_err,
    input int          exp_cyc,
    input int          hold,
    input bit          late_kick,
    input string       nm
  );
    int c;
    bit bad;
    rsp_t e;
    rsp_t snap;
    bit exp_drain;
    exp_drain = exp_err && !late_kick;
    sb.push_back(rsp_t'{exp_rd, w, exp_err});
    req_valid = 1'b1;
    req_write = w;
    req_addr = a;
    req_wdata = d;
    req_wstrb = s;
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s accept: req_ready=%b want 1", nm, req_ready);
    end
    step();
    req_valid = 1'b0;
    c = 1;
    tests++;
    if ({mem_write, mem_read} !== {w, !w} || mem_addr !== a ||
        mem_wdata !== d || mem_wstrb !== s) begin
      fails++;
      $display("FAIL %s cmd: wr/rd=%b%b addr=%h wdata=%h strb=%h want %b%b %h %h %h",
               nm, mem_write, mem_read, mem_addr, mem_wdata, mem_wstrb,
               w, !w, a, d, s);
    end
    bad = 1'b0;
    do begin
      step();
      c++;
      if (mem_write || mem_read || req_ready) bad = 1'b1;
    end while (!rsp_valid && c < 64);
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL %s pulse: extra pulse or req_ready while busy, got 1 want 0", nm);
    end
    tests++;
    if (c != exp_cyc) begin
      fails++;
      $display("FAIL %s latency: rsp_valid in cycle %0d want %0d", nm, c, exp_cyc);
    end
    e = sb.pop_front();
    tests++;
    if ({rsp_rdata, rsp_write, rsp_err} !== e) begin
      fails++;
      $display("FAIL %s rsp: rdata=%h write=%b err=%b want %h %b %b",
               nm, rsp_rdata, rsp_write, rsp_err, e.rdata, e.write, e.err);
    end
    snap = {rsp_rdata, rsp_write, rsp_err};
    if (hold > 0) begin
      bad = 1'b0;
      for (int k = 0; k < hold; k++) begin
        if (k == 0 && late_kick) kick = ~kick;
        step();
        if ({rsp_rdata, rsp_write, rsp_err} !== snap || rsp_valid !== 1'b1 ||
            req_ready || mem_write || mem_read) bad = 1'b1;
      end
      tests++;
      if (bad) begin
        fails++;
        $display("FAIL %s hold: rsp changed or activity under backpressure, got 1 want 0", nm);
      end
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    tests++;
    if (rsp_valid !== 1'b0 || req_ready !== !exp_drain) begin
      fails++;
      $display("FAIL %s done: rsp_valid=%b req_ready=%b want 0 %b",
               nm, rsp_valid, req_ready, !exp_drain);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    req_wstrb = '0;
    rsp_ready = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    tests++;
    if ({req_ready, rsp_valid, rsp_err, rsp_write, mem_read, mem_write} !== 6'b100000 ||
        rsp_rdata !== '0 || mem_addr !== '0 || mem_wdata !== '0 || mem_wstrb !== '0) begin
      fails++;
      $display("FAIL reset: ctl=%b rdata=%h addr=%h want 100000 0 0",
               {req_ready, rsp_valid, rsp_err, rsp_write, mem_read, mem_write},
               rsp_rdata, mem_addr);
    end
  endtask

  task automatic test_write();
    lat = 5;
    access(1'b1, 10'h010, 32'hA5A5_1234, 4'hF, 32'h0, 1'b0, 8, 0, 1'b0, "write");
  endtask

  task automatic test_read_back();
    lat = 5;
    access(1'b0, 10'h010, 32'h0, 4'h0, 32'hA5A5_1234, 1'b0, 8, 0, 1'b0, "read");
    access(1'b1, 10'h010, 32'hFFFF_0000, 4'h3, 32'h0, 1'b0, 8, 0, 1'b0, "pwrite");
    access(1'b0, 10'h010, 32'h0, 4'h0, 32'hA5A5_0000, 1'b0, 8, 0, 1'b0, "pread");
  endtask

  task automatic test_backpressure();
    lat = 5;
    access(1'b0, 10'h010, 32'h0, 4'h0, 32'hA5A5_0000, 1'b0, 8, 10, 1'b0, "bp");
  endtask

  task automatic test_back_to_back();
    int t0;
    lat = 0;
    access(1'b1, 10'h3FF, 32'h1357_9BDF, 4'hF, 32'h0, 1'b0, 3, 0, 1'b0, "w_l0");
    t0 = cyc;
    for (int i = 0; i < 10; i++)
      access(1'b0, (i[0] ? 10'h3FF : 10'h010), 32'h0, 4'h0,
             (i[0] ? 32'h1357_9BDF : 32'hA5A5_0000), 1'b0, 3, 0, 1'b0, "b2b");
    tests++;
    if (cyc - t0 != 40) begin
      fails++;
      $display("FAIL b2b_rate: %0d cycles want 40", cyc - t0);
    end
  endtask

  task automatic test_timeout();
    mute = 1'b1;
    access(1'b0, 10'h020, 32'h0, 4'h0, 32'h0, 1'b1, TO + 2, 0, 1'b0, "timeout");
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if (req_ready !== 1'b0) begin
        fails++;
        $display("FAIL drain_hold: req_ready=%b want 0", req_ready);
      end
    end
    kick = ~kick;
    step();
    tests++;
    if (req_ready !== 1'b0) begin
      fails++;
      $display("FAIL drain_late: req_ready=%b want 0", req_ready);
    end
    step();
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL drain_exit: req_ready=%b want 1", req_ready);
    end
    access(1'b1, 10'h021, 32'h0BAD_F00D, 4'hF, 32'h0, 1'b1, TO + 2, 3, 1'b1, "late_in_resp");
    mute = 1'b0;
    kick = ~kick;
    repeat (3) step();
    tests++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL spurious_idle: req_ready=%b rsp_valid=%b want 1 0",
               req_ready, rsp_valid);
    end
  endtask

  task automatic test_reset_mid_wait();
    lat = 5;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr = 10'h010;
    step();
    req_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    tests++;
    if ({req_ready, rsp_valid, rsp_err, rsp_write, mem_read, mem_write} !== 6'b100000 ||
        rsp_rdata !== '0 || mem_addr !== '0 || mem_wdata !== '0 || mem_wstrb !== '0) begin
      fails++;
      $display("FAIL mid_reset: ctl=%b addr=%h want 100000 0",
               {req_ready, rsp_valid, rsp_err, rsp_write, mem_read, mem_write}, mem_addr);
    end
    step();
    rst_n = 1'b1;
    repeat (8) step();
    tests++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL post_reset: req_ready=%b rsp_valid=%b want 1 0",
               req_ready, rsp_valid);
    end
    access(1'b0, 10'h010, 32'h0, 4'h0, 32'hA5A5_0000, 1'b0, 8, 0, 1'b0, "post_reset_rd");
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_back();
    test_backpressure();
    test_back_to_back();
    test_timeout();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_nzlat_initiator.md
# mem_nzlat_initiator

Initiator-side adapter that drives the team's nonzero-latency memory pulse protocol (one-cycle `read`/`write` command, one-cycle `ready` completion) from a core-facing valid/ready request/response interface. It serialises single outstanding accesses, captures read data on the completion cycle, and holds it in a response register under backpressure. It also bounds every access with a completion timeout. It sits between the core's load/store or fetch unit and the memory model/controller.

## Interface
- `DATA_WIDTH`, default 32: data bus width; must be a multiple of 8.
- `DEPTH`, default 1024: memory words; localparam `ADDR_WIDTH = $clog2(DEPTH)`.
- `TIMEOUT`, default 64: maximum number of WAIT cycles before an error response; 0 disables the timeout.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  core request valid.
- `req_ready`  out  1  block can accept a request.
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_WIDTH  word address.
- `req_wdata`  in  DATA_WIDTH  write data.
- `req_wstrb`  in  DATA_WIDTH/8  byte enables for writes.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  core accepts response.
- `rsp_rdata`  out  DATA_WIDTH  read data; 0 for writes and errors.
- `rsp_write`  out  1  echoes the `req_write` of the completed request.
- `rsp_err`  out  1  request timed out.
- `mem_addr`, `mem_wdata`, `mem_wstrb`  out  ADDR_WIDTH / DATA_WIDTH / DATA_WIDTH/8  command fields, registered.
- `mem_write`, `mem_read`  out  1  command pulses; at most one of them is high, for exactly one cycle.
- `mem_rdata`  in  DATA_WIDTH  memory read data; valid only while `mem_ready`=1.
- `mem_ready`  in  1  one-cycle completion strobe.

## Operation
- All outputs are registered except `req_ready`, which is decoded from the state.
- Reset values: state IDLE; `rsp_valid`, `rsp_err`, `rsp_write`, `mem_read`, `mem_write` = 0; `rsp_rdata`, `mem_addr`, `mem_wdata`, `mem_wstrb` = 0. The timeout counter and the late-ready flag are cleared.
- States:
  - IDLE: `req_ready`=1. On `req_valid`, latch `req_write`/addr/wdata/wstrb into the `mem_*` registers and go to ISSUE.
  - ISSUE: `mem_write`=`req_write` and `mem_read`=!`req_write` for this single cycle. Next state is WAIT and the timeout counter clears. `mem_ready` sampled in ISSUE is ignored.
  - WAIT: if `mem_ready`=1, load `rsp_rdata`=`mem_rdata` (0 for writes), set `rsp_err`=0 and `rsp_valid`=1, and go to RESP. If `mem_ready`=0 and the counter equals TIMEOUT-1 (TIMEOUT≠0), load `rsp_rdata`=0, set `rsp_err`=1 and `rsp_valid`=1, clear the late flag, and go to RESP. Otherwise the counter increments.
  - RESP: hold all `rsp_*` outputs stable. `mem_ready` seen during RESP sets the late flag. On `rsp_ready`, clear `rsp_valid`. Then go to IDLE, unless `rsp_err`=1 and the late flag is clear, in which case go to DRAIN.
  - DRAIN: `req_ready`=0. Wait for `mem_ready`, discard it, then go to IDLE. A DRAIN that never completes is cleared only by reset.
- `mem_addr`/`mem_wdata`/`mem_wstrb` hold their values from ISSUE until the next accept.
- `mem_ready` in IDLE is spurious and ignored; no state change.
- Exactly one access is outstanding at a time. `req_ready`=0 in every state except IDLE.
- Counter width is `$clog2(TIMEOUT+1)`. It must not wrap: it saturates at TIMEOUT-1.
- Reset mid-operation returns to IDLE with all outputs at reset values. The partial memory access is abandoned; the memory shares `rst_n`.

## Timing
- Request accepted at edge ending cycle 0. `mem_read`/`mem_write`=1 in cycle 1 only.
- For a memory with latency L, `mem_ready` arrives in cycle L+2. `rsp_valid`=1 from cycle L+3.
- With `rsp_ready`=1, IDLE and `req_ready`=1 return in cycle L+4. The memory is idle from cycle L+3, so the next command pulse (cycle L+5) is never lost.
- Back-to-back throughput: one access per L+4 cycles.
- TIMEOUT must be ≥ L+1 for error-free operation, since WAIT lasts L+1 cycles.
- Error response appears TIMEOUT+1 cycles after ISSUE, i.e. `rsp_valid` in cycle TIMEOUT+2.

## Test plan
- Write: L=5; write addr 0x010, wdata 0xA5A5_1234, wstrb 0xF -> `mem_write`=1 in cycle 1 only; `rsp_valid` in cycle 8 with `rsp_write`=1, `rsp_err`=0, `rsp_rdata`=0.
- Read-back: read addr 0x010 -> `mem_read` single pulse; `rsp_rdata`=0xA5A5_1234 in cycle 8 after accept. A partial write with wstrb=0x3, wdata 0xFFFF_0000 followed by a read returns 0xA5A5_0000.
- Backpressure: hold `rsp_ready`=0 for 10 cycles -> `rsp_*` outputs stable, `req_ready`=0, no `mem_*` pulses; the handshake in cycle 11 returns to IDLE the next cycle.
- Latency 0 memory: `mem_ready` in cycle 2 and `rsp_valid` in cycle 3. Ten back-to-back reads with `rsp_ready`=1 each complete in exactly 4 cycles.
- Timeout: TIMEOUT=4 with a responder that never asserts `mem_ready` -> `rsp_err`=1 with `rsp_rdata`=0 in cycle 6. After the response handshake the block stays in DRAIN (`req_ready`=0) until a late `mem_ready`, then returns to IDLE.
- Reset: assert `rst_n`=0 during WAIT -> all outputs 0 and IDLE with `req_ready`=1 once reset releases; a subsequent read completes normally.
